// File: rtl/upsample2x_nn.sv
// Nearest-neighbour 2x upsampler: ping-pong row buffers, each row is replayed twice
// with every channel group duplicated, behind a ready/valid output with a one-entry skid.
module upsample2x_nn #(
    parameter int DATA_WIDTH  = 8,
    parameter int STRING_LEN  = 112,
    parameter int CHANNEL_NUM = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  ready_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  overflow_o,
    output logic                  len_err_o
);
    localparam int DEPTH = STRING_LEN * CHANNEL_NUM;
    localparam int IW    = $clog2(2 * DEPTH);
    localparam int LW    = $clog2(DEPTH + 2);
    localparam int CW    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] C_L     = LW'(CHANNEL_NUM);
    localparam logic [CW-1:0] C_M1    = CW'(CHANNEL_NUM - 1);

    typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;
    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } meta_t;

    logic [DATA_WIDTH-1:0] ram [0:2*DEPTH-1];

    // writer state
    logic                 wsel_q, wsel_d, wr_act_q, wr_act_d, wr_buf_q, wr_buf_d;
    logic                 wr_sof_q, wr_sof_d;
    logic [LW-1:0]        wr_cnt_q, wr_cnt_d, wr_addr, cnt_new;
    logic [1:0]           full_q, full_d, sof_tag_q, sof_tag_d, eof_tag_q, eof_tag_d;
    logic [1:0][LW-1:0]   len_q, len_d;
    logic                 overflow_q, overflow_d, len_err_q, len_err_d, rdy_en_q;
    logic                 we, commit;
    logic [IW-1:0]        wr_idx, rd_idx;
    logic [1:0]           buf_free;

    // reader state
    state_t               state_q, state_d;
    logic                 rd_buf_q, rd_buf_d, dup_q, dup_d;
    logic [LW-1:0]        base_q, base_d, rd_addr;
    logic [CW-1:0]        ch_q, ch_d;
    logic                 pass1, ch_last, px_last, first, last, issue, rel;
    meta_t                iss_meta;

    // output pipeline: R holds the RAM read, S is the skid
    logic                  r_vld_q, r_vld_d, s_vld_q, s_vld_d;
    logic [DATA_WIDTH-1:0] r_data_q, s_data_q, s_data_d;
    meta_t                 r_meta_q, r_meta_d, s_meta_q, s_meta_d, out_meta;

    always_comb begin
        pass1    = (state_q == PASS1);
        ch_last  = (ch_q == C_M1);
        px_last  = (base_q + C_L) >= len_q[rd_buf_q];
        first    = (base_q == '0) && !dup_q && (ch_q == '0);
        last     = ch_last && dup_q && px_last;
        // issue never looks at ready_i; the skid catches the one read in flight
        issue    = !s_vld_q && ((state_q != IDLE) || full_q[rd_buf_q]);
        rel      = issue && last && pass1;
        rd_addr  = base_q + LW'(ch_q);
        rd_idx   = rd_buf_q ? IW'(DEPTH) + IW'(rd_addr) : IW'(rd_addr);
        iss_meta = '{sop: first, eop: last,
                     sof: first && !pass1 && sof_tag_q[rd_buf_q],
                     eof: last && pass1 && eof_tag_q[rd_buf_q]};

        state_d  = state_q;
        rd_buf_d = rd_buf_q;
        base_d   = base_q;
        ch_d     = ch_q;
        dup_d    = dup_q;
        if (issue) begin
            if (ch_last) begin
                ch_d  = '0;
                dup_d = !dup_q;
                if (dup_q) base_d = px_last ? '0 : base_q + C_L;
            end else begin
                ch_d = ch_q + 1'b1;
            end
            if (last) begin
                if (pass1) begin
                    rd_buf_d = !rd_buf_q;
                    state_d  = full_q[!rd_buf_q] ? PASS0 : IDLE;
                end else begin
                    state_d = PASS1;
                end
            end else if (state_q == IDLE) begin
                state_d = PASS0;
            end
        end

        r_vld_d  = r_vld_q;
        r_meta_d = r_meta_q;
        s_vld_d  = s_vld_q;
        s_data_d = s_data_q;
        s_meta_d = s_meta_q;
        if (s_vld_q) begin
            if (ready_i) s_vld_d = 1'b0;
        end else if (r_vld_q) begin
            if (ready_i) begin
                r_vld_d = 1'b0;
            end else if (issue) begin
                s_vld_d  = 1'b1;
                s_data_d = r_data_q;
                s_meta_d = r_meta_q;
            end
        end
        if (issue) begin
            r_vld_d  = 1'b1;
            r_meta_d = iss_meta;
        end
    end

    assign buf_free[0] = !full_q[0] || (rel && !rd_buf_q);
    assign buf_free[1] = !full_q[1] || (rel && rd_buf_q);

    always_comb begin
        wsel_d     = wsel_q;
        wr_act_d   = wr_act_q;
        wr_buf_d   = wr_buf_q;
        wr_sof_d   = wr_sof_q;
        full_d     = full_q;
        len_d      = len_q;
        sof_tag_d  = sof_tag_q;
        eof_tag_d  = eof_tag_q;
        overflow_d = overflow_q;
        len_err_d  = len_err_q;
        we         = 1'b0;
        wr_addr    = '0;
        commit     = 1'b0;
        cnt_new    = wr_cnt_q;
        if (rel) full_d[rd_buf_q] = 1'b0;
        if (data_valid_i && sop_i) begin
            if (buf_free[wsel_q]) begin
                wr_act_d = 1'b1;
                wr_buf_d = wsel_q;
                wsel_d   = !wsel_q;
                wr_sof_d = sof_i;
                we       = 1'b1;
                cnt_new  = LW'(1);
                commit   = eop_i;
            end else begin
                // a dropped row does not advance the selector so order stays aligned with the reader
                overflow_d = 1'b1;
                wr_act_d   = 1'b0;
            end
        end else if (data_valid_i && wr_act_q) begin
            we      = (wr_cnt_q < DEPTH_L);
            wr_addr = wr_cnt_q;
            cnt_new = (wr_cnt_q > DEPTH_L) ? wr_cnt_q : wr_cnt_q + 1'b1;
            commit  = eop_i;
        end
        wr_cnt_d = cnt_new;
        if (commit) begin
            wr_act_d            = 1'b0;
            full_d[wr_buf_d]    = 1'b1;
            len_d[wr_buf_d]     = (cnt_new > DEPTH_L) ? DEPTH_L : cnt_new;
            sof_tag_d[wr_buf_d] = wr_sof_d;
            eof_tag_d[wr_buf_d] = eof_i;
            if (cnt_new != DEPTH_L) len_err_d = 1'b1;
        end
        wr_idx = wr_buf_d ? IW'(DEPTH) + IW'(wr_addr) : IW'(wr_addr);
    end

    always_ff @(posedge clk) begin
        if (we) ram[wr_idx] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset)      r_data_q <= '0;
        else if (issue) r_data_q <= ram[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wsel_q     <= 1'b0;
            wr_act_q   <= 1'b0;
            wr_buf_q   <= 1'b0;
            wr_sof_q   <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            len_q      <= '0;
            sof_tag_q  <= '0;
            eof_tag_q  <= '0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
            state_q    <= IDLE;
            rd_buf_q   <= 1'b0;
            base_q     <= '0;
            ch_q       <= '0;
            dup_q      <= 1'b0;
            r_vld_q    <= 1'b0;
            r_meta_q   <= '0;
            s_vld_q    <= 1'b0;
            s_data_q   <= '0;
            s_meta_q   <= '0;
        end else begin
            wsel_q     <= wsel_d;
            wr_act_q   <= wr_act_d;
            wr_buf_q   <= wr_buf_d;
            wr_sof_q   <= wr_sof_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
            len_q      <= len_d;
            sof_tag_q  <= sof_tag_d;
            eof_tag_q  <= eof_tag_d;
            overflow_q <= overflow_d;
            len_err_q  <= len_err_d;
            rdy_en_q   <= 1'b1;
            state_q    <= state_d;
            rd_buf_q   <= rd_buf_d;
            base_q     <= base_d;
            ch_q       <= ch_d;
            dup_q      <= dup_d;
            r_vld_q    <= r_vld_d;
            r_meta_q   <= r_meta_d;
            s_vld_q    <= s_vld_d;
            s_data_q   <= s_data_d;
            s_meta_q   <= s_meta_d;
        end
    end

    assign ready_o      = rdy_en_q && buf_free[wsel_q];
    assign data_valid_o = s_vld_q || r_vld_q;
    assign data_o       = s_vld_q ? s_data_q : r_data_q;
    assign out_meta     = s_vld_q ? s_meta_q : r_meta_q;
    assign sop_o        = out_meta.sop && data_valid_o;
    assign eop_o        = out_meta.eop && data_valid_o;
    assign sof_o        = out_meta.sof && data_valid_o;
    assign eof_o        = out_meta.eof && data_valid_o;
    assign overflow_o   = overflow_q;
    assign len_err_o    = len_err_q;
endmodule
